// File: rtl/deserialize_pkg.sv
// Shared serial-link definitions: default frame width and the FSM state encodings used by
// both the serializer and the deserializer.
package deserialize_pkg;

  localparam int unsigned DefaultMsgSize = 8;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

endpackage

// File: rtl/deserialize.sv
// LSB-first serial-to-parallel converter feeding the encryptor through a valid/ack handshake.
// A frame finishing while the previous word is still unconsumed is dropped and flagged.
module deserialize
  import deserialize_pkg::*;
#(
  parameter int unsigned MSG_SIZE = DefaultMsgSize
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iStart,
  input  logic                iData,
  input  logic                iAck,
  output logic [MSG_SIZE-1:0] oPlaintext,
  output logic                oValid,
  output logic                oBusy,
  output logic                oOverrun
);

  localparam int unsigned     CntW    = $clog2(MSG_SIZE);
  localparam logic [CntW-1:0] LastBit = CntW'(MSG_SIZE - 1);

  logic [0:0]          stateQ, stateD;
  logic [CntW-1:0]     countQ, countD;
  // The final bit goes straight into oPlaintext, so only MSG_SIZE-1 bits are staged.
  logic [MSG_SIZE-2:0] shiftQ, shiftD;
  logic [MSG_SIZE-1:0] plainQ, plainD;
  logic                validQ, validD;
  logic                overrunQ, overrunD;
  logic                complete;

  always_comb begin
    stateD   = stateQ;
    countD   = countQ;
    shiftD   = shiftQ;
    plainD   = plainQ;
    validD   = validQ;
    overrunD = overrunQ;
    complete = 1'b0;

    case (stateQ)
      StIdle: begin
        if (iEn && iStart) begin
          shiftD[0] = iData;
          countD    = CntW'(1);
          stateD    = StShift;
        end
      end
      StShift: begin
        if (iEn) begin
          if (countQ == LastBit) begin
            complete = 1'b1;
            countD   = '0;
            stateD   = StIdle;
          end else begin
            shiftD[countQ] = iData;
            countD         = countQ + CntW'(1);
          end
        end
      end
      default: stateD = StIdle;
    endcase

    if (complete) begin
      if (!validQ || iAck) begin
        plainD = {iData, shiftQ};
        validD = 1'b1;
      end else begin
        overrunD = 1'b1;
      end
    end else if (iAck && validQ) begin
      validD = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      stateQ   <= StIdle;
      countQ   <= '0;
      shiftQ   <= '0;
      plainQ   <= '0;
      validQ   <= 1'b0;
      overrunQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      countQ   <= countD;
      shiftQ   <= shiftD;
      plainQ   <= plainD;
      validQ   <= validD;
      overrunQ <= overrunD;
    end
  end

  assign oPlaintext = plainQ;
  assign oValid     = validQ;
  assign oBusy      = (stateQ == StShift);
  assign oOverrun   = overrunQ;

endmodule
